// File: rtl/round_key_store_pkg.sv
// Shared AES key-store constants and state encodings.
// Imported by round_key_ram and round_key_store.
package round_key_store_pkg;

  localparam int KEY_S            = 128;
  localparam int Nr               = 10;
  localparam int ROUND_KEY_ADDR_W = 4;

  typedef enum logic [0:0] {
    RKS_IDLE   = 1'b0,
    RKS_STREAM = 1'b1
  } rks_state_t;

  function automatic logic idx_ok(
    input logic [ROUND_KEY_ADDR_W-1:0] a,
    input int                          nr
  );
    return int'(a) <= nr;
  endfunction

endpackage

// File: rtl/round_key_ram.sv
// Round key table: (NR+1) x KEY_W entries.
// One synchronous write port and one registered read port.
module round_key_ram
  import round_key_store_pkg::*;
#(
  parameter int KEY_W  = KEY_S,
  parameter int NR     = Nr,
  parameter int ADDR_W = ROUND_KEY_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [KEY_W-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [KEY_W-1:0]  rd_data
);

  logic [KEY_W-1:0] mem [0:NR];

  // Table contents survive reset; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (wr_en && (int'(wr_addr) <= NR)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/round_key_store.sv
// Round key store: captures expanded keys, streams them over valid/ready.
// Define ROUND_KEY_STORE_DEC_EN to enable reverse (decrypt) order.
module round_key_store
  import round_key_store_pkg::*;
#(
  parameter int KEY_W  = KEY_S,
  parameter int NR     = Nr,
  parameter int ADDR_W = ROUND_KEY_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [KEY_W-1:0]  wr_data,
  input  logic              exp_done,
  input  logic              start,
  input  logic              decrypt,
  output logic              rk_valid,
  input  logic              rk_ready,
  output logic [KEY_W-1:0]  rk_data,
  output logic [ADDR_W-1:0] rk_round,
  output logic              rk_last,
  output logic              keys_valid,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NR);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  rks_state_t        state;
  logic              abort;
  logic              fire;
  logic              start_ok;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] first_idx;
  logic [ADDR_W-1:0] step_idx;
  logic              step_last;

  // A write to round 0 means a fresh expansion has begun.
  assign abort    = wr_en && (wr_addr == '0);
  assign fire     = rk_valid && rk_ready;
  assign start_ok = (state == RKS_IDLE) && start
                 && keys_valid && !abort;

`ifdef ROUND_KEY_STORE_DEC_EN
  logic rev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rev <= 1'b0;
    end else if (start_ok) begin
      rev <= decrypt;
    end
  end

  assign first_idx = decrypt ? LAST_IDX : '0;
  assign step_idx  = rev ? rk_round - ONE : rk_round + ONE;
  assign step_last = rev ? (step_idx == '0)
                         : (step_idx == LAST_IDX);
`else
  logic unused_decrypt;

  assign unused_decrypt = decrypt;
  assign first_idx      = '0;
  assign step_idx       = rk_round + ONE;
  assign step_last      = (step_idx == LAST_IDX);
`endif

  assign rd_en = start_ok
              || ((state == RKS_STREAM) && fire
                  && !rk_last && !abort);
  assign rd_addr = start_ok ? first_idx : step_idx;

  round_key_ram #(
    .KEY_W  (KEY_W),
    .NR     (NR),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rk_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      keys_valid <= 1'b0;
    end else if (abort) begin
      keys_valid <= 1'b0;
    end else if (exp_done) begin
      keys_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RKS_IDLE;
      rk_valid <= 1'b0;
      rk_round <= '0;
      rk_last  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      unique case (state)
        RKS_IDLE: begin
          if (start_ok) begin
            state    <= RKS_STREAM;
            rk_valid <= 1'b1;
            busy     <= 1'b1;
            rk_round <= first_idx;
            rk_last  <= 1'b0;
          end
        end
        RKS_STREAM: begin
          if (abort || (fire && rk_last)) begin
            state    <= RKS_IDLE;
            rk_valid <= 1'b0;
            busy     <= 1'b0;
            rk_last  <= 1'b0;
          end else if (fire) begin
            rk_round <= step_idx;
            rk_last  <= step_last;
          end
        end
        default: begin
          state    <= RKS_IDLE;
          rk_valid <= 1'b0;
          busy     <= 1'b0;
          rk_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule
